// File: rtl/key_conditioner.sv
// Key conditioner: synchronizes and debounces one active-low push-button and
// turns it into clean press/release pulses plus an optional hold-to-repeat train.
module key_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
    parameter int unsigned HOLD_CYCLES     = 50_000_000,
    parameter int unsigned REPEAT_CYCLES   = 10_000_000,
    parameter int unsigned EN_REPEAT       = 1
) (
    input  logic clk100_i,
    input  logic rst_i,
    input  logic key_i,
    output logic pressed_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o,
    output logic long_o
);

    localparam int unsigned   DW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s2_q;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic          pressed_q, pressed_d;
    logic          press_q, press_d;
    logic          release_q, release_d;

    // The pad idles high, so the synchronizer resets to the released level.
    always_ff @(posedge clk100_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            db_cnt_q  <= '0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            s1_q      <= key_i;
            s2_q      <= s1_q;
            db_cnt_q  <= db_cnt_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        db_cnt_d  = db_cnt_q;
        pressed_d = pressed_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (~s2_q == pressed_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            pressed_d = ~s2_q;
            db_cnt_d  = '0;
            press_d   = ~s2_q;
            release_d = s2_q;
        end else begin
            db_cnt_d = db_cnt_q + DW'(1);
        end
    end

    assign pressed_o = pressed_q;
    assign press_o   = press_q;
    assign release_o = release_q;

    generate
        if (EN_REPEAT != 0) begin : g_repeat
            localparam int unsigned TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
            localparam int unsigned TW   = $clog2(TMAX + 1);
            localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
            localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);

            typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_REPEAT} state_t;

            state_t        state_q;
            logic [TW-1:0] tm_q;
            logic          repeat_q, long_q;

            // Release is checked before timer expiry so it always wins a tie.
            always_ff @(posedge clk100_i or posedge rst_i) begin
                if (rst_i) begin
                    state_q  <= ST_IDLE;
                    tm_q     <= '0;
                    repeat_q <= 1'b0;
                    long_q   <= 1'b0;
                end else begin
                    repeat_q <= 1'b0;
                    case (state_q)
                        ST_IDLE: begin
                            if (press_d) begin
                                state_q <= ST_HOLD;
                                tm_q    <= '0;
                            end
                        end
                        ST_HOLD: begin
                            if (release_d) begin
                                state_q <= ST_IDLE;
                                long_q  <= 1'b0;
                                tm_q    <= '0;
                            end else if (tm_q == HOLD_LAST) begin
                                state_q  <= ST_REPEAT;
                                repeat_q <= 1'b1;
                                long_q   <= 1'b1;
                                tm_q     <= '0;
                            end else begin
                                tm_q <= tm_q + TW'(1);
                            end
                        end
                        ST_REPEAT: begin
                            if (release_d) begin
                                state_q <= ST_IDLE;
                                long_q  <= 1'b0;
                                tm_q    <= '0;
                            end else if (tm_q == REP_LAST) begin
                                repeat_q <= 1'b1;
                                tm_q     <= '0;
                            end else begin
                                tm_q <= tm_q + TW'(1);
                            end
                        end
                        default: begin
                            state_q <= ST_IDLE;
                            long_q  <= 1'b0;
                            tm_q    <= '0;
                        end
                    endcase
                end
            end

            assign repeat_o = repeat_q;
            assign long_o   = long_q;
        end else begin : g_no_repeat
            assign repeat_o = 1'b0;
            assign long_o   = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: one instance with repeat logic and one
// without, both driven by the same key/reset and checked every clock.
module tb_key_conditioner;

    localparam int unsigned DB   = 4;
    localparam int unsigned HOLD = 10;
    localparam int unsigned REP  = 3;

    logic clock = 1'b0;
    logic reset;
    logic keyRaw;

    logic pressedA, pressA, releaseA, repeatA, longA;
    logic pressedB, pressB, releaseB, repeatB, longB;
    logic [4:0] outsA, outsB;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    key_conditioner #(
        .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .EN_REPEAT(1)
    ) dutRep (
        .clk100_i(clock), .rst_i(reset), .key_i(keyRaw),
        .pressed_o(pressedA), .press_o(pressA), .release_o(releaseA),
        .repeat_o(repeatA), .long_o(longA)
    );

    key_conditioner #(
        .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .EN_REPEAT(0)
    ) dutNoRep (
        .clk100_i(clock), .rst_i(reset), .key_i(keyRaw),
        .pressed_o(pressedB), .press_o(pressB), .release_o(releaseB),
        .repeat_o(repeatB), .long_o(longB)
    );

    // Output vector order: {pressed, press, release, repeat, long}
    assign outsA = {pressedA, pressA, releaseA, repeatA, longA};
    assign outsB = {pressedB, pressB, releaseB, repeatB, longB};

    task automatic checkOutput(input string tag, input logic [4:0] observed, input logic [4:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", tag, $time, observed, expected);
        end
    endtask

    // The no-repeat instance must match on the debounce outputs and keep repeat/long at 0.
    task automatic checkBoth(input string tag, input logic [4:0] expected);
        checkOutput({tag, "/rep"}, outsA, expected);
        checkOutput({tag, "/norep"}, outsB, {expected[4:2], 2'b00});
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic keyValue, input int edges, input logic [4:0] expected, input string tag);
        keyRaw = keyValue;
        for (int i = 0; i < edges; i++) begin
            tick();
            checkBoth(tag, expected);
        end
    endtask

    function automatic logic repeatAt(input int e);
        return (e >= int'(HOLD)) && (((e - int'(HOLD)) % int'(REP)) == 0);
    endfunction

    initial begin
        reset  = 1'b1;
        keyRaw = 1'b0;

        // Key held low throughout reset: nothing may come out until debounce after exit.
        applyStimulus(1'b0, 5, 5'b00000, "rst_hold");
        reset = 1'b0;
        applyStimulus(1'b0, 5, 5'b00000, "rst_exit_wait");
        tick(); checkBoth("rst_exit_press", 5'b11000);
        tick(); checkBoth("rst_exit_held", 5'b10000);
        applyStimulus(1'b1, 5, 5'b10000, "s1_rel_wait");
        tick(); checkBoth("s1_release", 5'b00100);
        tick(); checkBoth("s1_idle", 5'b00000);

        // Clean press, long hold with repeats, then release mid-REPEAT.
        applyStimulus(1'b0, 5, 5'b00000, "s2_wait");
        tick(); checkBoth("s2_press", 5'b11000);
        for (int e = 1; e <= 20; e++) begin
            tick();
            checkBoth("s4_hold", {1'b1, 1'b0, 1'b0, repeatAt(e), (e >= int'(HOLD))});
        end
        keyRaw = 1'b1;
        for (int e = 21; e <= 25; e++) begin
            tick();
            checkBoth("s5_rel_wait", {1'b1, 1'b0, 1'b0, repeatAt(e), 1'b1});
        end
        tick(); checkBoth("s5_release", 5'b00100);
        applyStimulus(1'b1, 3, 5'b00000, "s5_after");

        // Release acceptance lands on the same edge as a repeat expiry.
        applyStimulus(1'b0, 5, 5'b00000, "s5b_wait");
        tick(); checkBoth("s5b_press", 5'b11000);
        for (int e = 1; e <= 7; e++) begin
            tick();
            checkBoth("s5b_hold", 5'b10000);
        end
        keyRaw = 1'b1;
        for (int e = 8; e <= 12; e++) begin
            tick();
            checkBoth("s5b_rel_wait", {1'b1, 1'b0, 1'b0, (e == 10), (e >= 10)});
        end
        tick(); checkBoth("s5b_tie", 5'b00100);
        applyStimulus(1'b1, 2, 5'b00000, "s5b_after");

        // Bounce: three low, one high, then steady low from edge 5.
        applyStimulus(1'b0, 3, 5'b00000, "s3_low");
        applyStimulus(1'b1, 1, 5'b00000, "s3_bounce");
        applyStimulus(1'b0, 5, 5'b00000, "s3_wait");
        tick(); checkBoth("s3_press", 5'b11000);
        tick(); checkBoth("s3_held", 5'b10000);
        applyStimulus(1'b1, 5, 5'b10000, "s3_rel_wait");
        tick(); checkBoth("s3_release", 5'b00100);
        tick(); checkBoth("s3_idle", 5'b00000);

        // Async reset mid-REPEAT, key kept held, then a fresh press after exit.
        applyStimulus(1'b0, 5, 5'b00000, "s6_wait");
        tick(); checkBoth("s6_press", 5'b11000);
        for (int e = 1; e <= 11; e++) begin
            tick();
            checkBoth("s6_hold", {1'b1, 1'b0, 1'b0, repeatAt(e), (e >= int'(HOLD))});
        end
        #2;
        reset = 1'b1;
        #1;
        checkBoth("s6_async_rst", 5'b00000);
        applyStimulus(1'b0, 3, 5'b00000, "s6_in_rst");
        reset = 1'b0;
        applyStimulus(1'b0, 5, 5'b00000, "s6_exit_wait");
        tick(); checkBoth("s6_repress", 5'b11000);
        tick(); checkBoth("s6_reheld", 5'b10000);
        applyStimulus(1'b1, 5, 5'b10000, "s6_rel_wait");
        tick(); checkBoth("s6_release", 5'b00100);
        tick(); checkBoth("s6_idle", 5'b00000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
